// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response-mux state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERR1,
    ST_ERR2
  } resp_state_t;

  // True when the manager is requesting a real transfer (NONSEQ/SEQ).
  function automatic logic ahb_is_xfer(input logic [1:0] htrans);
    logic r;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_resp_watchdog.sv
// Counts consecutive wait states of the selected subordinate and flags expiry.
// Latency: expire is combinational in the TIMEOUT_CYCLES-th consecutive wait cycle.
// Backpressure: none; any non-wait cycle clears the count (TIMEOUT_CYCLES=0 never expires).
module ahb_resp_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic wait_cyc,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  // Expiry fires on the wait cycle whose edge would take the count to TIMEOUT_CYCLES.
  always_comb begin
    expire = (TIMEOUT_CYCLES != 0) && wait_cyc && (cnt >= LIMIT);
  end

  // Saturating wait counter; cleared on any ready cycle, state change or expiry.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
    end else if (!wait_cyc || expire) begin
      cnt <= '0;
    end else if (cnt != {CW{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite subordinate response mux with decode-error default slave and wait-state watchdog.
// Latency: zero added latency; outputs are combinational from registered state and selected slice.
// Backpressure: HREADY follows the selected subordinate; error responses insert one low cycle.
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int NO_OF_SUBORDINATES = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                                     HCLK,
  input  logic                                     HRESETn,
  input  logic [NO_OF_SUBORDINATES-1:0]            HSEL,
  input  logic [1:0]                               HTRANS,
  input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
  input  logic [2*NO_OF_SUBORDINATES-1:0]          HRESP_S,
  input  logic [DATA_WIDTH*NO_OF_SUBORDINATES-1:0] HRDATA_S,
  output logic [DATA_WIDTH-1:0]                    HRDATA,
  output logic [1:0]                               HRESP,
  output logic                                     HREADY,
  output logic                                     decode_err,
  output logic                                     timeout_err
);

  localparam int SW = (NO_OF_SUBORDINATES > 1) ? $clog2(NO_OF_SUBORDINATES) : 1;

  resp_state_t           state, state_nxt;
  logic [SW-1:0]         sel_idx, sel_nxt;
  logic                  err_to, err_to_nxt;
  logic [4:0]            hot_cnt;
  logic [SW-1:0]         hot_idx;
  logic                  sel_rdy;
  logic [1:0]            sel_resp;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wait_cyc;
  logic                  expire;

  // One-hot check of the decoder selects: population count plus index of the set bit.
  always_comb begin
    hot_cnt = '0;
    hot_idx = '0;
    for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
      if (HSEL[i]) begin
        hot_cnt = hot_cnt + 5'd1;
        hot_idx = SW'(i);
      end
    end
  end

  // Route the registered subordinate's slice.
  always_comb begin
    sel_rdy  = HREADYOUT_S[sel_idx];
    sel_resp = HRESP_S[2*sel_idx +: 2];
    sel_data = HRDATA_S[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    wait_cyc = (state == ST_ACTIVE) && !sel_rdy;
  end

  ahb_resp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .wait_cyc (wait_cyc),
    .expire   (expire)
  );

  // Manager-facing outputs decoded from state; ERR1/ERR2 form the two-cycle ERROR response.
  always_comb begin
    HREADY      = 1'b1;
    HRESP       = HRESP_OKAY;
    HRDATA      = '0;
    decode_err  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      ST_ACTIVE: begin
        HREADY = sel_rdy;
        HRESP  = sel_resp;
        HRDATA = sel_data;
      end
      ST_ERR1: begin
        HREADY      = 1'b0;
        HRESP       = HRESP_ERROR;
        decode_err  = !err_to;
        timeout_err = err_to;
      end
      ST_ERR2: begin
        HRESP = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Next state: address phase is taken only when HREADY is high; watchdog expiry forces ERR1.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_idx;
    err_to_nxt = 1'b0;
    if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (HREADY) begin
      if (!ahb_is_xfer(HTRANS)) begin
        state_nxt = ST_IDLE;
      end else if (hot_cnt == 5'd1) begin
        state_nxt = ST_ACTIVE;
        sel_nxt   = hot_idx;
      end else begin
        state_nxt = ST_ERR1;
      end
    end else if (expire) begin
      state_nxt  = ST_ERR1;
      err_to_nxt = 1'b1;
    end
  end

  // State, selected index and error cause registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      err_to  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_idx <= sel_nxt;
      err_to  <= err_to_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Self-checking bench for ahb_resp_mux_n (N=4, DATA_WIDTH=32, TIMEOUT_CYCLES=16).
// Latency: expected responses derived per transfer from the protocol rules.
// Backpressure: wait states and stalls driven on the selected subordinate.
module tb_ahb_resp_mux_n;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N-1:0]    HSEL;
  logic [1:0]      HTRANS;
  logic [N-1:0]    HREADYOUT_S;
  logic [2*N-1:0]  HRESP_S;
  logic [DW*N-1:0] HRDATA_S;
  logic [DW-1:0]   HRDATA;
  logic [1:0]      HRESP;
  logic            HREADY;
  logic            decode_err;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;

  ahb_resp_mux_n #(
    .NO_OF_SUBORDINATES(N),
    .DATA_WIDTH        (DW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HTRANS      (HTRANS),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADY      (HREADY),
    .decode_err  (decode_err),
    .timeout_err (timeout_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [1:0] resp,
                         input logic [31:0] data, input logic derr, input logic terr);
    chk({tag, ".hready"},      32'(HREADY),      32'(rdy));
    chk({tag, ".hresp"},       32'(HRESP),       32'(resp));
    chk({tag, ".hrdata"},      HRDATA,           data);
    chk({tag, ".decode_err"},  32'(decode_err),  32'(derr));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(terr));
  endtask

  // Random traffic on every subordinate port.
  task automatic rand_subs();
    HREADYOUT_S = N'($urandom);
    HRESP_S     = (2*N)'($urandom);
    HRDATA_S    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Advance to just after the next rising edge; the address bus carries junk that
  // must be ignored unless the next call drives a real address phase.
  task automatic next_cyc();
    @(posedge HCLK);
    #1;
    HSEL   = N'($urandom);
    HTRANS = 2'($urandom);
  endtask

  // One transfer: drive its address phase (caller is after a negedge of a cycle with
  // HREADY=1), then check every data-phase cycle. waits >= TO means a permanent stall.
  task automatic xfer(input string tag, input logic [3:0] hsel, input logic [1:0] htrans,
                      input int waits, input logic [31:0] data, input logic [1:0] resp);
    int idx;
    int hot;
    logic [31:0] junk;
    hot = $countones(hsel);
    idx = 0;
    for (int i = 0; i < N; i++) if (hsel[i]) idx = i;
    HSEL   = hsel;
    HTRANS = htrans;
    next_cyc();
    if (!htrans[1]) begin
      rand_subs();
      @(negedge HCLK);
      chk_out({tag, ".idle"}, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    end else if (hot != 1) begin
      rand_subs();
      @(negedge HCLK);
      chk_out({tag, ".derr1"}, 1'b0, 2'b01, 32'h0, 1'b1, 1'b0);
      next_cyc();
      rand_subs();
      @(negedge HCLK);
      chk_out({tag, ".derr2"}, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0);
    end else begin
      for (int c = 0; c < ((waits >= TO) ? TO : waits); c++) begin
        if (c != 0) next_cyc();
        rand_subs();
        junk = $urandom;
        HREADYOUT_S[idx]      = 1'b0;
        HRESP_S[2*idx +: 2]   = 2'b00;
        HRDATA_S[DW*idx +: DW] = junk;
        @(negedge HCLK);
        chk_out({tag, ".wait"}, 1'b0, 2'b00, junk, 1'b0, 1'b0);
      end
      if (waits != 0) next_cyc();
      rand_subs();
      if (waits >= TO) begin
        // The stalled subordinate waking up now must be ignored.
        HREADYOUT_S[idx] = 1'b1;
        @(negedge HCLK);
        chk_out({tag, ".terr1"}, 1'b0, 2'b01, 32'h0, 1'b0, 1'b1);
        next_cyc();
        rand_subs();
        @(negedge HCLK);
        chk_out({tag, ".terr2"}, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0);
      end else begin
        HREADYOUT_S[idx]       = 1'b1;
        HRESP_S[2*idx +: 2]    = resp;
        HRDATA_S[DW*idx +: DW] = data;
        @(negedge HCLK);
        chk_out({tag, ".done"}, 1'b1, resp, data, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    logic [3:0]  hsel;
    logic [1:0]  htrans;
    int          r;
    int          waits;

    HRESETn     = 1'b0;
    HSEL        = '0;
    HTRANS      = 2'b00;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    #1;
    chk_out("reset", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Directed scenarios.
    xfer("sub2_2wait",   4'b0100, 2'b10, 2,    32'hCAFE_0002, 2'b00);
    xfer("hsel_zero",    4'b0000, 2'b10, 0,    32'h0,         2'b00);
    xfer("hsel_multi",   4'b0011, 2'b10, 0,    32'h0,         2'b00);
    xfer("sub1_stall",   4'b0010, 2'b10, 1000, 32'h0,         2'b00);
    xfer("sub3_after",   4'b1000, 2'b10, 0,    32'h3333_0003, 2'b00);
    xfer("b2b_0",        4'b0001, 2'b10, 0,    32'hA000_0000, 2'b00);
    xfer("b2b_3",        4'b1000, 2'b11, 0,    32'hA000_0003, 2'b00);
    xfer("b2b_0b",       4'b0001, 2'b10, 0,    32'hB000_0000, 2'b00);
    xfer("sub1_15wait",  4'b0010, 2'b10, 15,   32'h1515_0001, 2'b00);
    xfer("sub2_errresp", 4'b0100, 2'b10, 1,    32'hEEEE_0002, 2'b01);
    xfer("idle_sel",     4'b0001, 2'b00, 0,    32'h0,         2'b00);
    xfer("busy_sel",     4'b0010, 2'b01, 0,    32'h0,         2'b00);

    // Reset asserted in the middle of a decode-error response.
    HSEL   = 4'b0000;
    HTRANS = 2'b10;
    next_cyc();
    rand_subs();
    @(negedge HCLK);
    chk_out("rst_pre", 1'b0, 2'b01, 32'h0, 1'b1, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_out("rst_mid", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    next_cyc();
    rand_subs();
    #1;
    chk_out("rst_hold", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    xfer("post_rst", 4'b0100, 2'b10, 1, 32'h5A5A_0002, 2'b00);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) != 0) hsel = 4'(1 << $urandom_range(0, 3));
      else                           hsel = 4'($urandom);
      htrans = 2'($urandom);
      r = $urandom_range(0, 11);
      if (r < 8)       waits = r % 4;
      else if (r < 10) waits = TO - 1;
      else if (r < 11) waits = 1;
      else             waits = 1000;
      xfer("rand", hsel, htrans, waits, $urandom, 2'($urandom_range(0, 1)));
    end

    HSEL   = '0;
    HTRANS = 2'b00;
    @(posedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux_n.md
AHB_RESP_MUX_N -- requirements
Module: ahb_resp_mux_n

Interface
REQ-001 Parameter NO_OF_SUBORDINATES, 4, number of subordinate response ports, range 1..16.
REQ-002 Parameter DATA_WIDTH, 32, read-data width in bits, 8..1024.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum consecutive wait states before forced ERROR; 0 disables the watchdog.
REQ-004 HCLK  in  1  single clock; all state on rising edge.
REQ-005 HRESETn  in  1  asynchronous active-low reset.
REQ-006 HSEL  in  NO_OF_SUBORDINATES  decoder selects, address phase, bit i = subordinate i.
REQ-007 HTRANS  in  2  manager transfer type, address phase.
REQ-008 HREADYOUT_S  in  NO_OF_SUBORDINATES  per-subordinate ready.
REQ-009 HRESP_S  in  2*NO_OF_SUBORDINATES  per-subordinate response, slice i at [2i+1:2i].
REQ-010 HRDATA_S  in  DATA_WIDTH*NO_OF_SUBORDINATES  per-subordinate read data, slice i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-011 HRDATA  out  DATA_WIDTH  read data to manager.
REQ-012 HRESP  out  2  response to manager; 2'b00 OKAY, 2'b01 ERROR.
REQ-013 HREADY  out  1  transfer-done to manager and back to all subordinates.
REQ-014 decode_err  out  1  one-cycle pulse: NONSEQ/SEQ with zero-hot or multi-hot HSEL.
REQ-015 timeout_err  out  1  one-cycle pulse: watchdog expiry.

Function
REQ-016 Address phase SHALL be sampled only on a rising HCLK where HREADY=1.
REQ-017 States: IDLE, ACTIVE, ERR1, ERR2; present-state registered, outputs combinational from state and selected slices.
REQ-018 On sample, HTRANS[1]=0 (IDLE/BUSY) -> IDLE regardless of HSEL.
REQ-019 On sample, HTRANS[1]=1 and HSEL one-hot -> ACTIVE, index of set bit registered as sel_idx.
REQ-020 On sample, HTRANS[1]=1 and HSEL zero-hot or multi-hot -> ERR1, decode_err=1 for that ERR1 cycle.
REQ-021 IDLE: HREADY=1, HRESP=OKAY, HRDATA=0 (built-in default subordinate, zero wait).
REQ-022 ACTIVE: HREADY/HRESP/HRDATA SHALL equal slice sel_idx of the subordinate inputs, zero added latency; subordinate ERROR responses pass through unchanged.
REQ-023 ERR1: HREADY=0, HRESP=ERROR, HRDATA=0; unconditional next state ERR2.
REQ-024 ERR2: HREADY=1, HRESP=ERROR, HRDATA=0; next state from address-phase sampling per REQ-018..020.
REQ-025 Watchdog counter: width clog2(TIMEOUT_CYCLES+1); cleared on every state entry and whenever selected HREADYOUT=1; increments each ACTIVE cycle with selected HREADYOUT=0, saturating.
REQ-026 Counter reaching TIMEOUT_CYCLES in ACTIVE with HREADYOUT still 0 -> ERR1 next cycle, timeout_err=1 for that ERR1 cycle; stalled subordinate's later outputs ignored.
REQ-027 Selected HREADYOUT rising on the same edge the counter expires SHALL win: transfer completes normally, no timeout.
REQ-028 TIMEOUT_CYCLES=0: no timeout ever; ACTIVE waits indefinitely.
REQ-029 Back-to-back transfers to different subordinates SHALL switch sel_idx on the completing edge with no bubble.

Reset
REQ-030 HRESETn low SHALL immediately force state IDLE, sel_idx=0, counter=0, giving HREADY=1, HRESP=OKAY, HRDATA=0, decode_err=0, timeout_err=0.
REQ-031 Reset asserted mid-transfer or mid-ERR SHALL abandon it; first post-reset edge with HREADY=1 samples a fresh address phase.

Structure
REQ-032 Shared package ahb_pkg SHALL hold HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings (OKAY/ERROR) and the state enum.
REQ-033 One sub-module ahb_resp_watchdog (counter + expiry flag, TIMEOUT_CYCLES parameter); one-hot decode and slice selection stay in top.

Verification (N=4, DATA_WIDTH=32, TIMEOUT_CYCLES=16)
REQ-034 NONSEQ HSEL=4'b0100, subordinate 2 returns 2 waits then HRDATA=32'hCAFE_0002 OKAY -> HREADY low 2 cycles, then HRDATA=32'hCAFE_0002, HRESP=00.
REQ-035 NONSEQ HSEL=4'b0000 -> decode_err pulse, HREADY 0/1 with HRESP=01 both cycles, HRDATA=0.
REQ-036 NONSEQ HSEL=4'b0011 -> same two-cycle ERROR as REQ-035, no subordinate data routed.
REQ-037 Subordinate 1 holds HREADYOUT=0 forever -> 16 wait cycles, then ERR1 with timeout_err=1, then ERR2; next NONSEQ to subordinate 3 completes normally.
REQ-038 Back-to-back NONSEQ to subordinates 0,3,0 zero-wait -> HRDATA follows slices 0,3,0 on consecutive cycles.
REQ-039 HRESETn low during ERR1 -> outputs immediately 1/00/0, pulses clear, next transfer sampled normally.
